// File: rtl/dac_wave_driver.sv
// Dual-channel periodic waveform generator driving a parallel-input dual DAC bus.
// Define DAC_LDAC_SYNC_EN to add the LOAD state so both channels update together on LDAC.
module dac_wave_driver #(
    parameter int DATA_W   = 8,
    parameter int BASE_DIV = 16,
    parameter int DIV_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [1:0]        Fsel,
    input  logic [2:0]        Fr,
    output logic [DATA_W-1:0] DB,
    output logic              CS,
    output logic              WR,
    output logic              AB,
    output logic              LDAC,
    output logic              CLR,
    output logic              PD,
    output logic              Ovr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP_A,
        S_STROBE_A,
        S_HOLD_A,
        S_SETUP_B,
        S_STROBE_B,
        S_HOLD_B
`ifdef DAC_LDAC_SYNC_EN
        , S_LOAD
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d, period_m1;
    logic [2:0]        fr_q, fr_d;
    logic [DATA_W:0]   ph_q, ph_d, ph_nxt;
    logic [DATA_W-1:0] db_q, db_d, sampb_q, sampb_d, samp_a, samp_b;
    logic              ab_q, ab_d, ovr_q, ovr_d, pd_q, pd_d, clr_q;
    logic              tick, run_tick;
    logic              cs_c, wr_c, ldac_c;

    function automatic logic [DATA_W-1:0] wave_map(input logic [1:0] sel, input logic [DATA_W:0] p);
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        logic              m;
        l = p[DATA_W-1:0];
        m = p[DATA_W];
        r = '0;
        case (sel)
            2'd0:    r = {DATA_W{m}};
            2'd1:    r = l;
            2'd2:    r = m ? ~l : l;
            default: r[DATA_W-1] = 1'b1;
        endcase
        return r;
    endfunction

    // Fr is only taken at reload, so the running period never changes length mid-count.
    assign period_m1 = (DIV_W'(BASE_DIV) << fr_q) - DIV_W'(1);
    assign tick      = (div_q == period_m1);
    assign run_tick  = tick & En;
    assign ph_nxt    = ph_q + (DATA_W+1)'(1);
    assign samp_a    = wave_map(Fsel, ph_nxt);
    assign samp_b    = wave_map(Fsel, {~ph_nxt[DATA_W], ph_nxt[DATA_W-1:0]});

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        fr_d  = tick ? Fr : fr_q;
    end

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        ab_d    = ab_q;
        sampb_d = sampb_q;
        ovr_d   = ovr_q;
        pd_d    = pd_q;
        ph_d    = run_tick ? ph_nxt : ph_q;
        cs_c    = 1'b1;
        wr_c    = 1'b1;
`ifdef DAC_LDAC_SYNC_EN
        ldac_c  = 1'b1;
`else
        ldac_c  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run_tick) begin
                    state_d = S_SETUP_A;
                    db_d    = samp_a;
                    ab_d    = 1'b0;
                    sampb_d = samp_b;
                end
            end
            S_SETUP_A:  begin cs_c = 1'b0; state_d = S_STROBE_A; end
            S_STROBE_A: begin cs_c = 1'b0; wr_c = 1'b0; state_d = S_HOLD_A; end
            S_HOLD_A: begin
                cs_c    = 1'b0;
                state_d = S_SETUP_B;
                db_d    = sampb_q;
                ab_d    = 1'b1;
            end
            S_SETUP_B:  begin cs_c = 1'b0; state_d = S_STROBE_B; end
            S_STROBE_B: begin cs_c = 1'b0; wr_c = 1'b0; state_d = S_HOLD_B; end
`ifdef DAC_LDAC_SYNC_EN
            S_HOLD_B:   begin cs_c = 1'b0; state_d = S_LOAD; end
            S_LOAD:     begin ldac_c = 1'b0; state_d = S_IDLE; end
`else
            S_HOLD_B:   begin cs_c = 1'b0; state_d = S_IDLE; end
`endif
            default:    state_d = S_IDLE;
        endcase
        // A tick landing mid-frame is dropped; the frame in flight keeps its snapshot.
        if (run_tick && (state_q != S_IDLE)) ovr_d = 1'b1;
        if (En) pd_d = 1'b1;
        else if (state_q == S_IDLE) pd_d = 1'b0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            fr_q    <= '0;
            ph_q    <= '0;
            db_q    <= '0;
            sampb_q <= '0;
            ab_q    <= 1'b0;
            ovr_q   <= 1'b0;
            pd_q    <= 1'b1;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            fr_q    <= fr_d;
            ph_q    <= ph_d;
            db_q    <= db_d;
            sampb_q <= sampb_d;
            ab_q    <= ab_d;
            ovr_q   <= ovr_d;
            pd_q    <= pd_d;
            clr_q   <= 1'b1;
        end
    end

    assign DB   = db_q;
    assign AB   = ab_q;
    assign CS   = cs_c;
    assign WR   = wr_c;
    assign LDAC = ldac_c;
    assign CLR  = clr_q;
    assign PD   = En | pd_q;
    assign Ovr  = ovr_q;

endmodule

// File: tb/tb_dac_wave_driver.sv
// Randomized directed bench for dac_wave_driver against an arithmetic phase/waveform model.
module tb_dac_wave_driver;
    localparam int DW   = 8;
    localparam int BD   = 16;
    localparam int HALF = 1 << DW;
    localparam int FULL = HALF - 1;
`ifdef DAC_LDAC_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int IDLE_OFF = (SYNC != 0) ? 3 : 2;

    logic          Clk, Rst, En;
    logic [1:0]    Fsel;
    logic [2:0]    Fr;
    logic [DW-1:0] DB;
    logic          CS, WR, AB, LDAC, CLR, PD, Ovr;

    logic          En2;
    logic [1:0]    Fsel2;
    logic [2:0]    Fr2;
    logic [DW-1:0] db2;
    logic          cs2, wr2, ab2, ldac2, clr2, pd2, ovr2;

    dac_wave_driver #(.DATA_W(DW), .BASE_DIV(BD), .DIV_W(16)) u_dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Fsel(Fsel), .Fr(Fr),
        .DB(DB), .CS(CS), .WR(WR), .AB(AB), .LDAC(LDAC), .CLR(CLR), .PD(PD), .Ovr(Ovr)
    );

    dac_wave_driver #(.DATA_W(DW), .BASE_DIV(4), .DIV_W(16)) u_ovr (
        .Clk(Clk), .Rst(Rst), .En(En2), .Fsel(Fsel2), .Fr(Fr2),
        .DB(db2), .CS(cs2), .WR(wr2), .AB(ab2), .LDAC(ldac2), .CLR(clr2), .PD(pd2), .Ovr(ovr2)
    );

    typedef struct {
        int            c;
        logic          ab;
        logic [DW-1:0] db;
        logic          cs;
    } wr_t;

    wr_t           wq[$];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            ph = 0;
    int            last_a = 0;
    int            fr_lat = 0;
    int            cur_fr = 0;
    int            cur_fsel = 0;
    bit            gap_known = 0;
    logic          ld_s[1:4];
    logic          cs_s[1:4];
    logic          pd_s[1:4];
    logic [DW-1:0] db_s;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk)
        if (Rst === 1'b0 && WR === 1'b0)
            wq.push_back('{c: cyc, ab: AB, db: DB, cs: CS});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_wave(input int fsel, input int p);
        case (fsel)
            0:       return (p >= HALF) ? FULL : 0;
            1:       return p % HALF;
            2:       return (p < HALF) ? p : (2 * HALF - 1) - p;
            default: return HALF / 2;
        endcase
    endfunction

    task automatic frame();
        wr_t a, b;
        int  n;
        n = 0;
        while (wq.size() < 2 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("frame_writes", wq.size(), 2);
        if (wq.size() < 2) return;
        a = wq.pop_front();
        b = wq.pop_front();
        ph = (ph + 1) % (2 * HALF);
        chk($sformatf("a_ab ph=%0d", ph), 32'(a.ab), 0);
        chk($sformatf("a_db ph=%0d fsel=%0d", ph, cur_fsel), 32'(a.db), ref_wave(cur_fsel, ph));
        chk("a_cs", 32'(a.cs), 0);
        chk($sformatf("b_ab ph=%0d", ph), 32'(b.ab), 1);
        chk($sformatf("b_db ph=%0d fsel=%0d", ph, cur_fsel), 32'(b.db), ref_wave(cur_fsel, ph ^ HALF));
        chk("b_cs", 32'(b.cs), 0);
        chk("wr_spacing", b.c - a.c, 3);
        if (gap_known) chk($sformatf("tick_gap fr=%0d", fr_lat), a.c - last_a, BD << fr_lat);
        last_a    = a.c;
        fr_lat    = cur_fr;
        gap_known = 1;
        for (int k = 1; k <= 4; k++) begin
            while (cyc < b.c + k) @(negedge Clk);
            ld_s[k] = LDAC;
            cs_s[k] = CS;
            pd_s[k] = PD;
            db_s    = DB;
        end
        chk("cs_hold_b", 32'(cs_s[1]), 0);
        chk("cs_release", 32'(cs_s[2]), 1);
        chk("ldac_hold_b", 32'(ld_s[1]), (SYNC != 0) ? 1 : 0);
        chk("ldac_load", 32'(ld_s[2]), 0);
        chk("ldac_after", 32'(ld_s[3]), (SYNC != 0) ? 1 : 0);
        chk("db_idle_hold", 32'(db_s), 32'(b.db));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            repeat ($urandom_range(0, 4)) @(negedge Clk);
        end
    endtask

    task automatic set_mode(input int fsel, input int fr);
        cur_fsel = fsel;
        cur_fr   = fr;
        Fsel     = 2'(fsel);
        Fr       = 3'(fr);
    endtask

    initial begin
        int n;
        Rst = 1'b1; En = 1'b0; Fsel = 2'd1; Fr = 3'd0;
        En2 = 1'b0; Fsel2 = 2'd2; Fr2 = 3'd0;

        // reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_db", 32'(DB), 0);
        chk("rst_cs", 32'(CS), 1);
        chk("rst_wr", 32'(WR), 1);
        chk("rst_ab", 32'(AB), 0);
        chk("rst_ldac", 32'(LDAC), (SYNC != 0) ? 1 : 0);
        chk("rst_pd", 32'(PD), 1);
        chk("rst_ovr", 32'(Ovr), 0);
        chk("rst_clr", 32'(CLR), 0);
        Rst = 1'b0;
        #1 chk("clr_after_release", 32'(CLR), 0);
        @(posedge Clk);
        #1 chk("clr_after_edge", 32'(CLR), 1);

        // sawtooth through a full wrap, then rate and waveform changes
        @(negedge Clk);
        set_mode(1, 0);
        En = 1'b1;
        run(260);
        set_mode(1, 3);
        run(2);
        set_mode(3, 3);
        run(2);
        set_mode(2, 2);
        run(260);

        for (int s = 0; s < 12; s++) begin
            set_mode($urandom_range(0, 3), $urandom_range(0, 1));
            run($urandom_range(2, 5));
        end

        // En drop during STROBE_A
        n = 0;
        while (!(WR === 1'b0 && AB === 1'b0) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_strobe_a", 32'(WR), 0);
        En = 1'b0;
        frame();
        chk("pd_at_idle", 32'(pd_s[IDLE_OFF]), 1);
        chk("pd_after_idle", 32'(pd_s[IDLE_OFF + 1]), 0);
        repeat (200 + $urandom_range(0, 100)) @(negedge Clk);
        chk("no_write_en_low", wq.size(), 0);
        chk("pd_low_idle", 32'(PD), 0);
        En = 1'b1;
        #1 chk("pd_reraise", 32'(PD), 1);
        gap_known = 0;
        run(3);
        chk("main_ovr_clear", 32'(Ovr), 0);

        // overrun on the short-period instance
        @(negedge Clk);
        chk("ovr2_init", 32'(ovr2), 0);
        En2 = 1'b1;
        n = 0;
        while (!(wr2 === 1'b0 && ab2 === 1'b0) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("ovr2_strobe_a", 32'(wr2), 0);
        chk("ovr2_a_db", 32'(db2), ref_wave(2, 1));
        chk("ovr2_before", 32'(ovr2), 0);
        n = 0;
        while (!(wr2 === 1'b0 && ab2 === 1'b1) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("ovr2_strobe_b", 32'(ab2), 1);
        chk("ovr2_b_db_kept", 32'(db2), ref_wave(2, 1 ^ HALF));
        chk("ovr2_set", 32'(ovr2), 1);
        n = 0;
        while (!(wr2 === 1'b0 && ab2 === 1'b0) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("ovr2_next_a_db", 32'(db2), ref_wave(2, 3));
        En2 = 1'b0;
        repeat (40) @(negedge Clk);
        chk("ovr2_sticky", 32'(ovr2), 1);

        // asynchronous reset in the middle of a frame
        n = 0;
        while (WR !== 1'b0 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_mid_frame", 32'(WR), 0);
        Rst = 1'b1;
        #1;
        chk("arst_wr", 32'(WR), 1);
        chk("arst_cs", 32'(CS), 1);
        chk("arst_db", 32'(DB), 0);
        chk("arst_ab", 32'(AB), 0);
        chk("arst_clr", 32'(CLR), 0);
        chk("arst_ovr2", 32'(ovr2), 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
